// File: rtl/dither_unpack_pkg.sv
// dither_unpack_pkg: shared FSM states and frame-geometry constants for the bitmap unpacker
package dither_unpack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DRAIN
    } state_t;

    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_WORD_W   = 16;
    localparam int ADDR_W       = 16;
    localparam int HCOUNT_W     = 11;
    localparam int VCOUNT_W     = 10;

    function automatic int frame_words(input int h, input int v, input int w);
        return h * v / w;
    endfunction

endpackage

// File: rtl/dither_unpack_word_fifo2.sv
// word_fifo2: two-entry word buffer with occupancy count
module word_fifo2 #(
    parameter int WORD_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] head,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] mem0, mem1;
    logic              wptr, rptr;

    assign head = rptr ? mem1 : mem0;

    // ping-pong storage: write side and read side each toggle their own pointer
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem0  <= '0;
            mem1  <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (wr_en && wptr)  mem1 <= wr_data;
            if (wr_en && !wptr) mem0 <= wr_data;
            if (wr_en) wptr <= ~wptr;
            if (rd_en) rptr <= ~rptr;
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

endmodule

// File: rtl/dither_unpack.sv
// dither_unpack: reads a packed 1-bit frame from word memory and expands it to a raster 8-bit pixel stream
module dither_unpack
    import dither_unpack_pkg::*;
#(
    parameter int         H_ACTIVE = DEF_H_ACTIVE,
    parameter int         V_ACTIVE = DEF_V_ACTIVE,
    parameter int         WORD_W   = DEF_WORD_W,
    parameter logic [7:0] ON_VALUE = 8'd255
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic                mem_rd_out,
    input  logic [WORD_W-1:0]   mem_rdata_in,
    output logic [7:0]          pixel_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                busy_out,
    output logic                frame_done_out
);

    localparam int NWORDS = frame_words(H_ACTIVE, V_ACTIVE, WORD_W);
    localparam int BW     = WORD_W > 1 ? $clog2(WORD_W) : 1;

    state_t            state;
    logic [16:0]       n_issued;
    logic [BW-1:0]     bit_idx;
    logic              p1, p2;
    logic [1:0]        occ;
    logic [WORD_W-1:0] head;
    logic [2:0]        reserved;
    logic              xfer, pop, last_px, all_issued, issue;

    // p1/p2 track a read through the two-cycle memory latency; p2 marks data on the bus now
    assign busy_out   = state != IDLE;
    assign valid_out  = busy_out && occ != 2'd0;
    assign pixel_out  = (valid_out && head[bit_idx]) ? ON_VALUE : 8'd0;
    assign xfer       = valid_out && ready_in;
    assign pop        = xfer && bit_idx == BW'(WORD_W - 1);
    assign last_px    = xfer && hcount_out == HCOUNT_W'(H_ACTIVE - 1) && vcount_out == VCOUNT_W'(V_ACTIVE - 1);
    assign all_issued = n_issued == 17'(NWORDS);
    assign reserved   = {1'b0, occ} + {2'b0, mem_rd_out} + {2'b0, p1} + {2'b0, p2};
    assign issue      = busy_out && !all_issued && (reserved - {2'b0, pop}) < 3'd2;

    word_fifo2 #(.WORD_W(WORD_W)) u_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .wr_en    (p2),
        .wr_data  (mem_rdata_in),
        .rd_en    (pop),
        .head     (head),
        .count    (occ)
    );

    // frame sequencing, read issue with buffer reservation, and raster position tracking
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            mem_rd_out     <= 1'b0;
            mem_addr_out   <= '0;
            n_issued       <= '0;
            p1             <= 1'b0;
            p2             <= 1'b0;
            bit_idx        <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            frame_done_out <= 1'b0;
        end else begin
            p1             <= mem_rd_out;
            p2             <= p1;
            frame_done_out <= last_px;
            mem_rd_out     <= 1'b0;
            case (state)
                IDLE: if (start_in) begin
                    state        <= PRIME;
                    mem_rd_out   <= 1'b1;
                    mem_addr_out <= '0;
                    n_issued     <= 17'd1;
                    bit_idx      <= '0;
                    hcount_out   <= '0;
                    vcount_out   <= '0;
                end
                PRIME:   if (p2) state <= STREAM;
                STREAM:  if (all_issued) state <= DRAIN;
                default: ;
            endcase
            if (issue) begin
                mem_rd_out   <= 1'b1;
                mem_addr_out <= n_issued[ADDR_W-1:0];
                n_issued     <= n_issued + 17'd1;
            end
            if (xfer) begin
                bit_idx    <= pop ? '0 : bit_idx + 1'b1;
                hcount_out <= hcount_out == HCOUNT_W'(H_ACTIVE - 1) ? '0 : hcount_out + 1'b1;
                if (hcount_out == HCOUNT_W'(H_ACTIVE - 1))
                    vcount_out <= vcount_out == VCOUNT_W'(V_ACTIVE - 1) ? '0 : vcount_out + 1'b1;
            end
            if (last_px) state <= IDLE;
        end
    end

endmodule

// File: tb/tb_dither_unpack.sv
// tb_dither_unpack: randomized and directed checks of dither_unpack against a bit-expansion reference model
module tb_dither_unpack;

    logic        clk = 1'b0;
    logic        rst_n, start, ready, sel;
    logic [15:0] rdata, d1;
    logic [15:0] mem [8];
    int          total = 0, passed = 0;

    logic [15:0] a_addr, b_addr, m_addr;
    logic        a_rd, b_rd, m_rd;
    logic [7:0]  a_pix, b_pix, m_pix;
    logic [10:0] a_h, b_h, m_h;
    logic [9:0]  a_v, b_v, m_v;
    logic        a_valid, b_valid, m_valid, a_busy, b_busy, m_busy, a_done, b_done, m_done;

    always #5 clk = ~clk;

    dither_unpack #(.H_ACTIVE(32), .V_ACTIVE(2), .WORD_W(16), .ON_VALUE(8'd255)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start & ~sel),
        .mem_addr_out(a_addr), .mem_rd_out(a_rd), .mem_rdata_in(rdata),
        .pixel_out(a_pix), .hcount_out(a_h), .vcount_out(a_v), .valid_out(a_valid),
        .ready_in(ready), .busy_out(a_busy), .frame_done_out(a_done)
    );

    dither_unpack #(.H_ACTIVE(20), .V_ACTIVE(4), .WORD_W(16), .ON_VALUE(8'd255)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start & sel),
        .mem_addr_out(b_addr), .mem_rd_out(b_rd), .mem_rdata_in(rdata),
        .pixel_out(b_pix), .hcount_out(b_h), .vcount_out(b_v), .valid_out(b_valid),
        .ready_in(ready), .busy_out(b_busy), .frame_done_out(b_done)
    );

    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_rd    = sel ? b_rd    : a_rd;
    assign m_pix   = sel ? b_pix   : a_pix;
    assign m_h     = sel ? b_h     : a_h;
    assign m_v     = sel ? b_v     : a_v;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;

    // word memory: data for a read appears on the bus two cycles after the strobe, noise otherwise
    always @(posedge clk) begin
        d1    <= m_rd ? mem[m_addr[2:0]] : 16'($urandom);
        rdata <= d1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {m_valid, m_busy, m_rd, m_done, m_addr, m_pix}, 32'd0);
        check({tag, "_pos"}, {m_h, m_v}, 32'd0);
    endtask

    task automatic fill_mem(input int kind);
        for (int k = 0; k < 8; k++) mem[k] = kind == 1 ? 16'hFFFF : 16'($urandom);
    endtask

    // mode 0: ready high, 1: five-cycle stall at pixel 10, 2: random ready plus stray starts
    task automatic run_frame(input bit s, input int mode, input int abort_at, output int first, output int done_c);
        int h, v, n, i, issued, dones, cyc, stall_left;
        bit held, stalled;
        logic [7:0]  pp, ep;
        logic [10:0] ph;
        logic [9:0]  pv;
        logic [15:0] w;
        h = s ? 20 : 32;
        v = s ? 4 : 2;
        n = h * v;
        i = 0; issued = 0; dones = 0; first = -1; done_c = -1;
        held = 0; stalled = 0; stall_left = 0;
        @(negedge clk);
        sel = s;
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 3000 && done_c < 0) begin
            if (m_done) begin dones++; done_c = cyc; end
            if (m_rd) begin
                issued++;
                check("rd_addr", {16'd0, m_addr}, issued - 1);
                check("reserve", {31'd0, (issued - i / 16) <= 2}, 32'd1);
            end
            if (held) begin
                check("hold_pix", {24'd0, m_pix}, {24'd0, pp});
                check("hold_pos", {m_h, m_v}, {ph, pv});
                check("hold_valid", {31'd0, m_valid}, 32'd1);
            end
            start = mode == 2 && (cyc == 20 || cyc == 40);
            if (mode == 1 && i == 10 && !stalled && m_valid) begin
                stalled = 1;
                stall_left = 5;
                check("stall_h", {21'd0, m_h}, 32'd10);
            end
            ready = mode == 2 ? 1'($urandom_range(0, 1)) : stall_left == 0;
            if (stall_left > 0) stall_left--;
            if (m_valid && first < 0) first = cyc;
            if (m_valid && ready) begin
                w  = mem[i / 16];
                ep = w[i % 16] ? 8'd255 : 8'd0;
                check("pixel", {24'd0, m_pix}, {24'd0, ep});
                check("hcount", {21'd0, m_h}, i % h);
                check("vcount", {22'd0, m_v}, i / h);
                i++;
            end
            held = m_valid && !ready;
            pp = m_pix; ph = m_h; pv = m_v;
            if (abort_at >= 0 && i == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                check_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                ready = 1'b1;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        check("done_seen", {31'd0, done_c >= 0}, 32'd1);
        check("pix_count", i, n);
        check("rd_count", issued, n / 16);
        repeat (12) begin
            @(negedge clk);
            if (m_done) dones++;
        end
        check("one_done", dones, 32'd1);
        check("idle_busy", {31'd0, m_busy}, 32'd0);
    endtask

    initial begin
        int f, d;
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        sel   = 1'b0;
        fill_mem(0);
        repeat (3) @(negedge clk);
        check_zero("rst_a");
        sel = 1'b1;
        #1;
        check_zero("rst_b");
        rst_n = 1'b1;
        ready = 1'b1;

        mem[0] = 16'h0001; mem[1] = 16'h8000; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
        run_frame(0, 0, -1, f, d);
        check("first_valid_a", f, 32'd3);
        check("done_cycle_a", d, 32'd67);

        fill_mem(0);
        run_frame(0, 1, -1, f, d);
        check("stall_done", d, 32'd72);

        fill_mem(0);
        run_frame(0, 2, -1, f, d);

        fill_mem(1);
        run_frame(1, 0, -1, f, d);
        check("first_valid_b", f, 32'd3);
        check("done_cycle_b", d, 32'd83);

        fill_mem(0);
        run_frame(1, 2, -1, f, d);

        fill_mem(0);
        run_frame(0, 0, 30, f, d);
        run_frame(0, 0, -1, f, d);
        check("restart_first", f, 32'd3);
        check("restart_done", d, 32'd67);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
